tblink_rpc_cmd_out_arb: RTL

Round-robin arbiter that shares the single cmd-out channel of `tblink_rpc_cmdproc` among `N_REQ` independent requesters. Each requester owns a toggle-handshake port identical in protocol to cmd-out. The arbiter latches the winning request, drives it onto cmd-out, waits for completion, and returns the response to the requester's private response register. It sits between the requesting endpoint BFMs and the `cmd_out_*` ports of `tblink_rpc_cmdproc`.

---
 rtl/tblink_rpc_pkg.sv | 12 +
 rtl/tblink_rpc_cmd_out_arb_if.sv | 51 +++++
 rtl/tblink_rpc_rr_pick.sv | 32 +++
 rtl/tblink_rpc_cmd_out_arb.sv | 99 +++++++++
 4 files changed

// File: rtl/tblink_rpc_pkg.sv
// Shared constants for the tblink RPC command path.
// Holds the arbiter state encoding and the byte width.
package tblink_rpc_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/tblink_rpc_cmd_out_arb_if.sv
// Requester ports plus the shared cmd-out channel of the arbiter.
// master is the arbiter; slave is the requesters and cmdproc.
interface tblink_rpc_cmd_out_arb_if
    import tblink_rpc_pkg::*;
#(
    parameter int N_REQ             = 4,
    parameter int CMD_OUT_PARAMS_SZ = 1,
    parameter int CMD_OUT_RSP_SZ    = 1
);
    localparam int ID_W = $clog2(N_REQ);
    localparam int PW   = CMD_OUT_PARAMS_SZ * BYTE_W;
    localparam int RW   = CMD_OUT_RSP_SZ * BYTE_W;

    logic [N_REQ*BYTE_W-1:0] req_cmd;
    logic [N_REQ*BYTE_W-1:0] req_sz;
    logic [N_REQ*PW-1:0]     req_params;
    logic [N_REQ-1:0]        req_put_i;
    logic [N_REQ-1:0]        req_get_i;
    logic [N_REQ*RW-1:0]     req_rsp;
    logic [N_REQ*BYTE_W-1:0] req_rsp_sz;

    logic [BYTE_W-1:0]       cmd_out;
    logic [BYTE_W-1:0]       cmd_out_sz;
    logic [PW-1:0]           cmd_out_params;
    logic                    cmd_out_put_i;
    logic                    cmd_out_get_i;
    logic [RW-1:0]           cmd_out_rsp;
    logic [BYTE_W-1:0]       cmd_out_rsp_sz;

    logic                    busy;
    logic [ID_W-1:0]         grant;

    modport master (
        input  req_cmd, req_sz, req_params, req_put_i,
        output req_get_i, req_rsp, req_rsp_sz,
        output cmd_out, cmd_out_sz, cmd_out_params,
        output cmd_out_put_i,
        input  cmd_out_get_i, cmd_out_rsp, cmd_out_rsp_sz,
        output busy, grant
    );

    modport slave (
        output req_cmd, req_sz, req_params, req_put_i,
        input  req_get_i, req_rsp, req_rsp_sz,
        input  cmd_out, cmd_out_sz, cmd_out_params,
        input  cmd_out_put_i,
        output cmd_out_get_i, cmd_out_rsp, cmd_out_rsp_sz,
        input  busy, grant
    );

endinterface

// File: rtl/tblink_rpc_rr_pick.sv
// Combinational round-robin picker: first pending index above last.
// Wrap is an explicit compare so N need not be a power of two.
module tblink_rpc_rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    pend_i,
    input  logic [ID_W-1:0] last_i,
    output logic            any_o,
    output logic [ID_W-1:0] idx_o
);

    logic [ID_W-1:0] cand;

    always_comb begin
        any_o = 1'b0;
        idx_o = '0;
        cand  = last_i;
        for (int i = 0; i < N; i++) begin
            if (cand == ID_W'(N - 1)) begin
                cand = '0;
            end else begin
                cand = cand + 1'b1;
            end
            if (!any_o && pend_i[cand]) begin
                any_o = 1'b1;
                idx_o = cand;
            end
        end
    end

endmodule

// File: rtl/tblink_rpc_cmd_out_arb.sv
// Round-robin arbiter sharing the cmdproc cmd-out toggle channel
// among N_REQ requesters, one transaction outstanding at a time.
module tblink_rpc_cmd_out_arb
    import tblink_rpc_pkg::*;
#(
    parameter int N_REQ             = 4,
    parameter int CMD_OUT_PARAMS_SZ = 1,
    parameter int CMD_OUT_RSP_SZ    = 1
) (
    input  logic                     uclock,
    input  logic                     reset_n,
    tblink_rpc_cmd_out_arb_if.master bus
);

    localparam int ID_W = $clog2(N_REQ);
    localparam int PW   = CMD_OUT_PARAMS_SZ * BYTE_W;
    localparam int RW   = CMD_OUT_RSP_SZ * BYTE_W;

    arb_state_e              state_q;
    logic                    put_q;
    logic [N_REQ-1:0]        get_q;
    logic [BYTE_W-1:0]       cmd_q;
    logic [BYTE_W-1:0]       sz_q;
    logic [PW-1:0]           params_q;
    logic [N_REQ*RW-1:0]     rsp_q;
    logic [N_REQ*BYTE_W-1:0] rsp_sz_q;
    logic                    busy_q;
    logic [ID_W-1:0]         grant_q;
    logic [ID_W-1:0]         last_q;

    logic [N_REQ-1:0]        pend_d;
    logic                    any_d;
    logic [ID_W-1:0]         idx_d;

    assign pend_d = bus.req_put_i ^ get_q;

    tblink_rpc_rr_pick #(
        .N    (N_REQ),
        .ID_W (ID_W)
    ) u_pick (
        .pend_i (pend_d),
        .last_i (last_q),
        .any_o  (any_d),
        .idx_o  (idx_d)
    );

    always_ff @(posedge uclock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ARB_IDLE;
            put_q    <= 1'b0;
            get_q    <= '0;
            cmd_q    <= '0;
            sz_q     <= '0;
            params_q <= '0;
            rsp_q    <= '0;
            rsp_sz_q <= '0;
            busy_q   <= 1'b0;
            grant_q  <= '0;
            last_q   <= ID_W'(N_REQ - 1);
        end else begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (any_d) begin
                        cmd_q    <= bus.req_cmd[int'(idx_d)*BYTE_W +: BYTE_W];
                        sz_q     <= bus.req_sz[int'(idx_d)*BYTE_W +: BYTE_W];
                        params_q <= bus.req_params[int'(idx_d)*PW +: PW];
                        grant_q  <= idx_d;
                        put_q    <= ~put_q;
                        busy_q   <= 1'b1;
                        state_q  <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    // put toggled on entry, so equality means cmdproc is done
                    if (bus.cmd_out_get_i == put_q) begin
                        rsp_q[int'(grant_q)*RW +: RW] <= bus.cmd_out_rsp;
                        rsp_sz_q[int'(grant_q)*BYTE_W +: BYTE_W] <=
                            bus.cmd_out_rsp_sz;
                        get_q[grant_q] <= ~get_q[grant_q];
                        last_q   <= grant_q;
                        busy_q   <= 1'b0;
                        state_q  <= ARB_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.req_get_i      = get_q;
    assign bus.req_rsp        = rsp_q;
    assign bus.req_rsp_sz     = rsp_sz_q;
    assign bus.cmd_out        = cmd_q;
    assign bus.cmd_out_sz     = sz_q;
    assign bus.cmd_out_params = params_q;
    assign bus.cmd_out_put_i  = put_q;
    assign bus.busy           = busy_q;
    assign bus.grant          = grant_q;

endmodule
